// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative 32-bit multiply/divide unit with register-file write-back
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        busy,
    output logic        rg_wrt_en,
    output logic [4:0]  rg_wrt_addr,
    output logic [31:0] rg_wrt_data
);

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Captured request; never touched again until the next accepted start.
    logic [1:0]  op_q;
    logic [4:0]  rd_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [4:0]  step_cnt;

    // Shared working register.
    // Multiply: {partial product high, multiplier bits still to consume / product low}.
    // Divide:   {partial remainder, dividend bits still to consume / quotient bits}.
    logic [63:0] work;

    logic        is_div;
    logic        last_step;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic [32:0] div_trial;
    logic [63:0] div_next;
    logic [63:0] work_next;
    logic [31:0] result_next;

    assign is_div    = op_q[1];
    assign last_step = (step_cnt == 5'd31);

    // busy comes straight from the state register so no input reaches an output.
    assign busy = (state != IDLE);

    // One shift-add or restoring shift-subtract iteration, plus result selection.
    always_comb begin
        mul_sum     = 33'd0;
        mul_next    = 64'd0;
        div_shift   = 33'd0;
        div_trial   = 33'd0;
        div_next    = 64'd0;
        work_next   = 64'd0;
        result_next = 32'd0;

        // Multiply: add multiplicand when the current multiplier LSB is set,
        // then shift the whole 65-bit {carry, high, low} right by one.
        mul_sum  = {1'b0, work[63:32]} + (work[0] ? {1'b0, a_q} : 33'd0);
        mul_next = {mul_sum, work[31:1]};

        // Divide: bring the next dividend bit into the remainder and try to
        // subtract. The 33-bit width keeps the bit shifted out of the remainder,
        // so bit 32 of the trial is a clean borrow flag. A zero divisor never
        // borrows, which yields an all-ones quotient and remainder == dividend.
        div_shift = {work[63:32], work[31]};
        div_trial = div_shift - {1'b0, b_q};
        if (!div_trial[32]) begin
            div_next = {div_trial[31:0], work[30:0], 1'b1};
        end else begin
            div_next = {div_shift[31:0], work[30:0], 1'b0};
        end

        work_next = is_div ? div_next : mul_next;

        case (op_q)
            OP_MUL:   result_next = work_next[31:0];
            OP_MULHU: result_next = work_next[63:32];
            OP_DIVU:  result_next = work_next[31:0];
            OP_REMU:  result_next = work_next[63:32];
            default:  result_next = 32'd0;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, 32 iterations in CALC, single-cycle DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, iteration datapath and registered write-back port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q        <= 2'd0;
            rd_q        <= 5'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            step_cnt    <= 5'd0;
            work        <= 64'd0;
            rg_wrt_en   <= 1'b0;
            rg_wrt_addr <= 5'd0;
            rg_wrt_data <= 32'd0;
        end else begin
            // Write-back fields are only non-zero for the single DONE cycle.
            rg_wrt_en   <= 1'b0;
            rg_wrt_addr <= 5'd0;
            rg_wrt_data <= 32'd0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        rd_q     <= rd_addr;
                        a_q      <= operand_a;
                        b_q      <= operand_b;
                        step_cnt <= 5'd0;
                        work     <= op[1] ? {32'd0, operand_a} : {32'd0, operand_b};
                    end
                end
                CALC: begin
                    work     <= work_next;
                    step_cnt <= step_cnt + 5'd1;
                    if (last_step) begin
                        rg_wrt_en   <= (rd_q != 5'd0);
                        rg_wrt_addr <= rd_q;
                        rg_wrt_data <= result_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (0 = reset asserted).
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  2  00 MUL (low 32 of product), 01 MULHU (high 32 of unsigned product), 10 DIVU, 11 REMU.
REQ-006 rd_addr  input  5  destination register index, captured with start.
REQ-007 operand_a  input  32  rs1 value (multiplicand / dividend), unsigned.
REQ-008 operand_b  input  32  rs2 value (multiplier / divisor), unsigned.
REQ-009 busy  output  1  high in CALC and DONE.
REQ-010 rg_wrt_en  output  1  register-file write enable, one-cycle pulse.
REQ-011 rg_wrt_addr  output  5  register-file write index.
REQ-012 rg_wrt_data  output  32  register-file write data.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-014 IDLE with start=1 at edge E0 SHALL capture op, rd_addr, operand_a and operand_b, clear the 5-bit step counter, and enter CALC.
REQ-015 start SHALL be ignored in CALC and DONE; a captured operation is never altered by input changes.
REQ-016 CALC SHALL perform one bit-iteration per edge over 32 edges (E1..E32): shift-add for MUL/MULHU, restoring shift-subtract for DIVU/REMU.
REQ-017 At the edge where counter==31 the final iteration SHALL complete and the FSM SHALL enter DONE.
REQ-018 Multiply SHALL form the full 64-bit unsigned product; MUL returns bits [31:0], MULHU returns bits [63:32].
REQ-019 Divide SHALL return the quotient for DIVU and the remainder for REMU, using a 33-bit trial subtraction so no carry is lost.
REQ-020 Divisor 0 SHALL produce DIVU=0xFFFFFFFF and REMU=operand_a with the same 32-step latency and no exception signal.
REQ-021 In DONE (between E32 and E33) rg_wrt_addr SHALL equal the captured rd, rg_wrt_data SHALL equal the result, and rg_wrt_en SHALL be 1 unless rd==0.
REQ-022 rd==0 SHALL complete the full sequence with rg_wrt_en held 0 throughout.
REQ-023 DONE SHALL last exactly one cycle and return to IDLE at E33; the earliest next accepted start is at E34.
REQ-024 Outside DONE, rg_wrt_en, rg_wrt_addr and rg_wrt_data SHALL be 0.
REQ-025 busy SHALL rise after E0 and fall after E33; busy is low in IDLE.
REQ-026 All outputs SHALL be driven from registers or from the state register only, with no combinational path from inputs to outputs.

Reset
REQ-027 reset=0 at any edge SHALL force IDLE, clear the counter and all operand/result registers, and drive busy, rg_wrt_en, rg_wrt_addr and rg_wrt_data to 0 from the next cycle on.
REQ-028 reset SHALL take priority over start; a start sampled with reset=0 is discarded.
REQ-029 A reset during CALC or DONE SHALL abort the operation with no write pulse, either then or afterwards.
REQ-030 After reset deasserts, the first edge with reset=1 and start=1 SHALL be accepted normally.

Verification
REQ-031 MUL: a=7, b=6, rd=5, start at E0 -> rg_wrt_en=1, addr=5, data=0x0000002A between E32 and E33 only; busy low from E34.
REQ-032 MULHU: a=b=0xFFFFFFFF, rd=3 -> data=0xFFFFFFFE; MUL with the same operands -> 0x00000001.
REQ-033 DIVU a=100, b=7 -> data=14 (0x0E); REMU with the same operands -> data=2; DIVU a=0x12345678, b=0 -> 0xFFFFFFFF; REMU with the same operands -> 0x12345678.
REQ-034 Start a MUL (rd=9), assert reset=0 for one edge at E10 -> no rg_wrt_en pulse through E40; busy=0 after the reset edge.
REQ-035 A second start with different operands pulsed at E5 and at E33 -> both ignored; the single write carries the first operation's result; start at E34 is accepted.
REQ-036 MUL a=3, b=4, rd=0 -> busy high E1..E33, rg_wrt_en never asserted.
